// File: rtl/generador_frecuencia.sv
// Square-wave generator: turns a 7-bit half-period word (in prescaled base ticks)
// into a 50% duty clk_out plus a one-cycle tick at the start of every period.
module generador_frecuencia #(
    parameter int PRESCALE = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] numdiv,
    input  logic       enable,
    output logic       clk_out,
    output logic       tick,
    output logic       busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN_HIGH,
        RUN_LOW
    } state_t;

    state_t        state;
    logic [6:0]    div_sh;
    logic [6:0]    half_cnt;
    logic [PW-1:0] pre_cnt;

    logic base_tick;
    logic phase_end;
    logic start_ok;

    assign base_tick = (pre_cnt == PRE_LAST);
    assign phase_end = base_tick && (half_cnt == (div_sh - 7'd1));
    assign start_ok  = enable && (numdiv != 7'd0);

    // Outputs are a registered image of the state, so they lag it by one cycle;
    // counters at zero in RUN_HIGH mark the first cycle of a period.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            div_sh   <= 7'd0;
            half_cnt <= 7'd0;
            pre_cnt  <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            clk_out <= (state == RUN_HIGH);
            busy    <= (state != IDLE);
            tick    <= (state == RUN_HIGH) && (pre_cnt == '0) && (half_cnt == 7'd0);

            case (state)
                IDLE: begin
                    pre_cnt  <= '0;
                    half_cnt <= 7'd0;
                    if (start_ok) begin
                        state  <= RUN_HIGH;
                        div_sh <= numdiv;
                    end
                end
                default: begin
                    pre_cnt <= base_tick ? '0 : pre_cnt + PW'(1);
                    if (phase_end)
                        half_cnt <= 7'd0;
                    else if (base_tick)
                        half_cnt <= half_cnt + 7'd1;

                    // A new divider is only taken at the low-to-high boundary.
                    if (phase_end) begin
                        if (state == RUN_HIGH) begin
                            state <= RUN_LOW;
                        end else if (start_ok) begin
                            state  <= RUN_HIGH;
                            div_sh <= numdiv;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_generador_frecuencia.sv
// Bench for generador_frecuencia (PRESCALE = 4): directed scenarios with measured
// run lengths, plus randomized inputs against a period-timeline model.
module tb_generador_frecuencia;

    localparam int P = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] numdiv;
    logic       enable;
    logic       clk_out;
    logic       tick;
    logic       busy;

    int errors = 0;
    int checks = 0;

    generador_frecuencia #(.PRESCALE(P)) dut (
        .clock  (clock),
        .reset  (reset),
        .numdiv (numdiv),
        .enable (enable),
        .clk_out(clk_out),
        .tick   (tick),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a period that starts at edge t0 with divider n shows its
    // outputs on edges t0+1 .. t0+2*n*P; the next decision is taken at t0+2*n*P.
    longint e_cnt = 0;
    longint m_t0 = 0;
    longint m_n = 0;
    longint off;
    bit     m_active = 0;
    bit     exp_clk = 0, exp_tick = 0, exp_busy = 0;

    always @(posedge clock) begin
        e_cnt++;
        if (reset) begin
            exp_clk = 0; exp_tick = 0; exp_busy = 0;
            m_active = 0;
        end else begin
            if (m_active) begin
                off = e_cnt - m_t0;
                exp_clk  = (off <= m_n * P);
                exp_tick = (off == 1);
                exp_busy = 1;
            end else begin
                exp_clk = 0; exp_tick = 0; exp_busy = 0;
            end
            if (!m_active) begin
                if (enable && numdiv != 0) begin
                    m_active = 1; m_t0 = e_cnt; m_n = numdiv;
                end
            end else if (e_cnt - m_t0 == 2 * m_n * P) begin
                if (enable && numdiv != 0) begin
                    m_t0 = e_cnt; m_n = numdiv;
                end else begin
                    m_active = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (e_cnt > 0)
            check("outputs{clk,tick,busy}", {29'd0, clk_out, tick, busy},
                  {29'd0, exp_clk, exp_tick, exp_busy});
    end

    // Run-length monitor feeding the literal expectations.
    int highs[$];
    int lows[$];
    int ivs[$];
    int hlen = 0, llen = 0, tick_cnt = 0;
    longint ncyc = 0, last_tick = -1;

    always @(negedge clock) begin
        ncyc++;
        if (clk_out) hlen++;
        else if (hlen != 0) begin highs.push_back(hlen); hlen = 0; end
        if (!clk_out && busy) llen++;
        else if (llen != 0) begin lows.push_back(llen); llen = 0; end
        if (tick) begin
            tick_cnt++;
            if (last_tick >= 0) ivs.push_back(int'(ncyc - last_tick));
            last_tick = ncyc;
        end
    end

    task automatic clear_meas();
        highs.delete(); lows.delete(); ivs.delete(); tick_cnt = 0;
    endtask

    task automatic cyc();
        @(negedge clock); #1;
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        do begin cyc(); n++; end while (!tick && n < 2200);
        if (!tick) check({name, "_timeout"}, 0, 1);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        int n;
        reset = 1'b1; enable = 1'b1; numdiv = 7'd13;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_clk", clk_out, 0);
            check("rst_tick", tick, 0);
            check("rst_busy", busy, 0);
        end
        reset = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (!tick && n < 10);
        check("first_tick_latency", n, 2);
        check("first_tick_clk", clk_out, 1);

        clear_meas();
        wait_tick("steady");
        check("steady_high", qget(highs, 0), 52);
        check("steady_low", qget(lows, 0), 52);
        check("steady_period", qget(ivs, 0), 104);

        clear_meas();
        repeat (19) cyc();
        numdiv = 7'd83;
        wait_tick("chg1");
        wait_tick("chg2");
        check("chg_old_high", qget(highs, 0), 52);
        check("chg_old_low", qget(lows, 0), 52);
        check("chg_new_high", qget(highs, 1), 332);
        check("chg_new_low", qget(lows, 1), 332);
        check("chg_period0", qget(ivs, 0), 104);
        check("chg_period1", qget(ivs, 1), 664);

        numdiv = 7'd25;
        wait_tick("drop_start");
        clear_meas();
        repeat (9) cyc();
        enable = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (busy && n < 500);
        check("drop_high", qget(highs, 0), 100);
        check("drop_low", qget(lows, 0), 100);
        repeat (100) cyc();
        check("drop_no_tick", tick_cnt, 0);
        check("drop_clk", clk_out, 0);
        check("drop_busy", busy, 0);

        numdiv = 7'd0; enable = 1'b1;
        repeat (20) cyc();
        check("zero_busy", busy, 0);
        check("zero_ticks", tick_cnt, 0);
        numdiv = 7'd1;
        wait_tick("min1");
        clear_meas();
        wait_tick("min2");
        wait_tick("min3");
        check("min_high", qget(highs, 0), 4);
        check("min_low", qget(lows, 0), 4);
        check("min_period0", qget(ivs, 0), 8);
        check("min_period1", qget(ivs, 1), 8);

        numdiv = 7'd50;
        wait_tick("mid_start");
        repeat (210) cyc();
        check("mid_in_low", {30'd0, clk_out, busy}, 1);
        reset = 1'b1;
        cyc();
        check("mid_rst_clk", clk_out, 0);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0;
        wait_tick("restart");
        clear_meas();
        n = 0;
        do begin cyc(); n++; end while (clk_out && n < 1000);
        check("restart_high", qget(highs, 0), 200);

        for (int i = 0; i < 4000; i++) begin
            reset  = ($urandom_range(0, 499) == 0);
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0)
                numdiv = 7'($urandom_range(0, 5));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
